m4_fb_write_arbiter: RTL and testbench

- Owns the write port of the dual-port framebuffer RAM.
- Shares that port between two requesters: the pixel-capture path (one write per dot) and an internal clear engine.
- Sequences 64/80-column mode changes: detects a stable line-length change, waits for frame start, clears all framebuffer words, then returns the port to capture.
- Sits between the capture logic and the RAM write side; the VGA reader side is untouched.

---
 rtl/m4_fb_pkg.sv | 24 ++
 rtl/m4_mode_detect.sv | 80 ++++++++
 rtl/m4_fb_write_arbiter.sv | 135 +++++++++++++
 tb/tb_m4_fb_write_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/m4_fb_pkg.sv
// rtl/m4_fb_pkg.sv - shared types and defaults for the framebuffer write arbiter
// Purpose: arbiter state encoding, screen-mode encodings, default sizes and thresholds.
// Ports: none (package).
package m4_fb_pkg;

  typedef enum logic [1:0] {
    PASS   = 2'd0,
    ARM    = 2'd1,
    CLEAR  = 2'd2,
    SETTLE = 2'd3
  } fb_state_t;

  localparam logic MODE_64 = 1'b1;
  localparam logic MODE_80 = 1'b0;

  localparam int FB_ADDR_W       = 18;
  localparam int FB_WORDS_DEF    = 192000;
  localparam int MODE_THRESH_DEF = 720;
  localparam int GLITCH_MIN_DEF  = 320;
  localparam int STABLE_DEF      = 4;

  typedef logic [FB_ADDR_W-1:0] fb_addr_t;

endpackage

// File: rtl/m4_mode_detect.sv
// rtl/m4_mode_detect.sv - line-length mode classifier and clear request latch
// Purpose: filters glitch lines, classifies 64/80-column lines, requires a run of
//   consecutive differing lines before requesting a mode change, and latches
//   force_clear requests until the arbiter consumes them.
// Ports:
//   dotclk, rst_n           clock and asynchronous active-low reset
//   line_len_valid/line_len end-of-line pulse and dot count
//   force_clear             request a clear keeping the current mode
//   screen_mode             mode currently applied by the arbiter
//   clear_ack               arbiter consumed the pending request this cycle
//   target_mode             mode to apply at the next clear
//   clear_pending           a clear pass is requested
module m4_mode_detect
  import m4_fb_pkg::*;
#(
  parameter int GLITCH_MIN   = GLITCH_MIN_DEF,
  parameter int MODE_THRESH  = MODE_THRESH_DEF,
  parameter int STABLE_LINES = STABLE_DEF
) (
  input  logic       dotclk,
  input  logic       rst_n,
  input  logic       line_len_valid,
  input  logic [9:0] line_len,
  input  logic       force_clear,
  input  logic       screen_mode,
  input  logic       clear_ack,
  output logic       target_mode,
  output logic       clear_pending
);

  localparam int CW = $clog2(STABLE_LINES + 1);
  localparam logic [9:0]    GLITCH_L = 10'(GLITCH_MIN);
  localparam logic [9:0]    THRESH_L = 10'(MODE_THRESH);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_LINES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] stable_cnt, cnt_n;
  logic          tgt_n, pend_n;
  logic          cand, eff_mode;

  assign cand     = (line_len > THRESH_L) ? MODE_80 : MODE_64;
  // While a change is pending, lines are judged against the mode about to be applied.
  assign eff_mode = clear_pending ? target_mode : screen_mode;

  always_comb begin
    cnt_n  = stable_cnt;
    tgt_n  = target_mode;
    pend_n = clear_pending;
    if (clear_ack) pend_n = 1'b0;
    // New requests are applied after the acknowledge so they are never lost.
    if (force_clear) begin
      pend_n = 1'b1;
      if (!clear_pending) tgt_n = screen_mode;
    end
    if (line_len_valid && (line_len > GLITCH_L)) begin
      if (cand == eff_mode) begin
        cnt_n = '0;
      end else if (stable_cnt == CNT_LAST) begin
        cnt_n  = '0;
        tgt_n  = cand;
        pend_n = 1'b1;
      end else begin
        cnt_n = stable_cnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge dotclk or negedge rst_n) begin
    if (!rst_n) begin
      stable_cnt    <= '0;
      target_mode   <= MODE_64;
      clear_pending <= 1'b0;
    end else begin
      stable_cnt    <= cnt_n;
      target_mode   <= tgt_n;
      clear_pending <= pend_n;
    end
  end

endmodule

// File: rtl/m4_fb_write_arbiter.sv
// rtl/m4_fb_write_arbiter.sv - framebuffer RAM write-port arbiter with clear engine
// Purpose: passes capture writes to the RAM write port, and on a mode change or
//   forced clear waits for frame start then zero-fills the whole framebuffer.
// Ports:
//   dotclk, rst_n                   clock and asynchronous active-low reset
//   pix_req/pix_addr/pix_data       capture write request
//   pix_ack                         previous-cycle request reached the RAM
//   line_len_valid/line_len         end-of-line pulse and dot count
//   frame_start, force_clear        frame sync pulse, clear request pulse
//   waddr/wdata/wren                RAM write port (registered)
//   screen_mode                     1 = 64-col, 0 = 80-col
//   clearing, clear_done            clear in progress / pass finished pulse
module m4_fb_write_arbiter
  import m4_fb_pkg::*;
#(
  parameter int ADDR_W       = FB_ADDR_W,
  parameter int FB_WORDS     = FB_WORDS_DEF,
  parameter int GLITCH_MIN   = GLITCH_MIN_DEF,
  parameter int MODE_THRESH  = MODE_THRESH_DEF,
  parameter int STABLE_LINES = STABLE_DEF
) (
  input  logic              dotclk,
  input  logic              rst_n,
  input  logic              pix_req,
  input  logic [ADDR_W-1:0] pix_addr,
  input  logic              pix_data,
  output logic              pix_ack,
  input  logic              line_len_valid,
  input  logic [9:0]        line_len,
  input  logic              frame_start,
  input  logic              force_clear,
  output logic [ADDR_W-1:0] waddr,
  output logic              wdata,
  output logic              wren,
  output logic              screen_mode,
  output logic              clearing,
  output logic              clear_done
);

  localparam logic [ADDR_W-1:0] CTR_LAST = ADDR_W'(FB_WORDS - 1);
  localparam logic [ADDR_W-1:0] CTR_ONE  = ADDR_W'(1);

  fb_state_t         state, state_n;
  logic [ADDR_W-1:0] clr_ctr, ctr_n, waddr_n;
  logic              wdata_n, wren_n, ack_n, mode_n, clearing_n, done_n;
  logic              target_mode, clear_pending, clear_ack;

  m4_mode_detect #(
    .GLITCH_MIN  (GLITCH_MIN),
    .MODE_THRESH (MODE_THRESH),
    .STABLE_LINES(STABLE_LINES)
  ) u_mode_detect (
    .dotclk        (dotclk),
    .rst_n         (rst_n),
    .line_len_valid(line_len_valid),
    .line_len      (line_len),
    .force_clear   (force_clear),
    .screen_mode   (screen_mode),
    .clear_ack     (clear_ack),
    .target_mode   (target_mode),
    .clear_pending (clear_pending)
  );

  always_ff @(posedge dotclk or negedge rst_n) begin
    if (!rst_n) state <= PASS;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    waddr_n   = waddr;
    wdata_n   = wdata;
    wren_n    = 1'b0;
    ack_n     = 1'b0;
    mode_n    = screen_mode;
    done_n    = 1'b0;
    ctr_n     = clr_ctr;
    clear_ack = 1'b0;
    case (state)
      PASS: begin
        waddr_n = pix_addr;
        wdata_n = pix_data;
        wren_n  = pix_req;
        ack_n   = pix_req;
        if (clear_pending) state_n = ARM;
      end
      ARM: begin
        // Capture requests are dropped here; the mode switches as the clear begins.
        if (frame_start) begin
          state_n   = CLEAR;
          ctr_n     = '0;
          mode_n    = target_mode;
          clear_ack = 1'b1;
        end
      end
      CLEAR: begin
        wren_n  = 1'b1;
        wdata_n = 1'b0;
        waddr_n = clr_ctr;
        // Holding at the last address keeps the counter from ever wrapping.
        if (clr_ctr == CTR_LAST) state_n = SETTLE;
        else                     ctr_n   = clr_ctr + CTR_ONE;
      end
      SETTLE: begin
        done_n  = 1'b1;
        state_n = PASS;
      end
      default: state_n = PASS;
    endcase
    clearing_n = (state_n == ARM) || (state_n == CLEAR);
  end

  always_ff @(posedge dotclk or negedge rst_n) begin
    if (!rst_n) begin
      waddr       <= '0;
      wdata       <= 1'b0;
      wren        <= 1'b0;
      pix_ack     <= 1'b0;
      screen_mode <= MODE_64;
      clearing    <= 1'b0;
      clear_done  <= 1'b0;
      clr_ctr     <= '0;
    end else begin
      waddr       <= waddr_n;
      wdata       <= wdata_n;
      wren        <= wren_n;
      pix_ack     <= ack_n;
      screen_mode <= mode_n;
      clearing    <= clearing_n;
      clear_done  <= done_n;
      clr_ctr     <= ctr_n;
    end
  end

endmodule

// File: tb/tb_m4_fb_write_arbiter.sv
// tb/tb_m4_fb_write_arbiter.sv - self-checking bench for m4_fb_write_arbiter
module tb_m4_fb_write_arbiter;

  localparam int AW     = 18;
  localparam int FB     = 200;
  localparam int GLITCH = 320;
  localparam int THRESH = 720;
  localparam int STABLE = 4;

  logic          dotclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pix_req = 1'b0;
  logic [AW-1:0] pix_addr = '0;
  logic          pix_data = 1'b0;
  logic          pix_ack;
  logic          line_len_valid = 1'b0;
  logic [9:0]    line_len = '0;
  logic          frame_start = 1'b0;
  logic          force_clear = 1'b0;
  logic [AW-1:0] waddr;
  logic          wdata, wren, screen_mode, clearing, clear_done;

  int n_chk = 0;
  int n_err = 0;

  m4_fb_write_arbiter #(.ADDR_W(AW), .FB_WORDS(FB)) dut (
    .dotclk(dotclk), .rst_n(rst_n),
    .pix_req(pix_req), .pix_addr(pix_addr), .pix_data(pix_data), .pix_ack(pix_ack),
    .line_len_valid(line_len_valid), .line_len(line_len),
    .frame_start(frame_start), .force_clear(force_clear),
    .waddr(waddr), .wdata(wdata), .wren(wren),
    .screen_mode(screen_mode), .clearing(clearing), .clear_done(clear_done)
  );

  always #5 dotclk = ~dotclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 capture, 1 waiting for frame, 2 clearing, 3 finishing.
  int            m_phase, m_left, m_cnt;
  logic          m_pending, m_target, m_mode, m_rst;
  logic          e_wren, e_ack, e_wdata, e_done, e_clearing;
  logic [AW-1:0] e_waddr;
  int            clr_writes;
  int            n_done;
  int            pass_len[$];

  always @(posedge dotclk) begin
    if (!rst_n) begin
      m_phase = 0; m_left = 0; m_cnt = 0;
      m_pending = 0; m_target = 1; m_mode = 1; m_rst = 1;
      e_wren = 0; e_ack = 0; e_wdata = 0; e_done = 0; e_clearing = 0; e_waddr = '0;
    end else begin
      int   ph_o;
      logic pend_o, mode_o, tgt_o, cand, eff;
      ph_o = m_phase; pend_o = m_pending; mode_o = m_mode; tgt_o = m_target;
      m_rst = 0; e_wren = 0; e_ack = 0; e_done = 0;
      case (ph_o)
        0: begin
          e_wren = pix_req; e_ack = pix_req; e_waddr = pix_addr; e_wdata = pix_data;
          if (pend_o) m_phase = 1;
        end
        1: if (frame_start) begin
          m_phase = 2; m_left = FB; m_mode = tgt_o; m_pending = 0;
        end
        2: begin
          e_wren = 1; e_wdata = 0; e_waddr = AW'(FB - m_left);
          m_left--;
          if (m_left == 0) m_phase = 3;
        end
        default: begin
          e_done = 1; m_phase = 0;
        end
      endcase
      e_clearing = (m_phase == 1) || (m_phase == 2);
      if (force_clear) begin
        m_pending = 1;
        if (!pend_o) m_target = mode_o;
      end
      if (line_len_valid && line_len > GLITCH) begin
        cand = (line_len > THRESH) ? 1'b0 : 1'b1;
        eff  = pend_o ? tgt_o : mode_o;
        if (cand == eff) m_cnt = 0;
        else begin
          m_cnt++;
          if (m_cnt == STABLE) begin m_target = cand; m_pending = 1; m_cnt = 0; end
        end
      end
    end
    #1;
    chk("wren", wren, e_wren);
    chk("pix_ack", pix_ack, e_ack);
    chk("clear_done", clear_done, e_done);
    chk("clearing", clearing, e_clearing);
    chk("screen_mode", screen_mode, m_mode);
    if (e_wren || m_rst) begin
      chk("waddr", waddr, e_waddr);
      chk("wdata", wdata, e_wdata);
    end
    if (!rst_n) clr_writes = 0;
    else begin
      if (wren && !pix_ack) clr_writes++;
      if (clear_done) begin
        pass_len.push_back(clr_writes);
        clr_writes = 0;
        n_done++;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge dotclk);
  endtask

  task automatic send_line(input int len);
    line_len = 10'(len); line_len_valid = 1;
    @(negedge dotclk);
    line_len_valid = 0;
    cycles(3);
  endtask

  task automatic pulse_fs();
    frame_start = 1;
    @(negedge dotclk);
    frame_start = 0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!clear_done && n < FB + 100) begin @(negedge dotclk); n++; end
    chk(nm, clear_done, 1);
    if (clear_done) chk({nm, "_len"}, pass_len[$], FB);
    @(negedge dotclk);
  endtask

  task automatic wait_addr(input int a, input string nm);
    int n = 0;
    while (!(wren && !pix_ack && waddr == AW'(a)) && n < FB + 100) begin @(negedge dotclk); n++; end
    chk(nm, waddr, a);
  endtask

  initial begin
    int d0;
    clr_writes = 0; n_done = 0;
    cycles(3);
    chk("rst_wren", wren, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_mode", screen_mode, 1);
    rst_n = 1;
    cycles(2);

    // Capture pass-through with 1-cycle latency.
    pix_req = 1; pix_addr = 18'h00123; pix_data = 1;
    @(posedge dotclk); #2;
    chk("pass_wren", wren, 1);
    chk("pass_waddr", waddr, 18'h00123);
    chk("pass_wdata", wdata, 1);
    chk("pass_ack", pix_ack, 1);
    @(negedge dotclk);
    pix_addr = 18'h3FFFF; pix_data = 0; @(negedge dotclk);
    pix_addr = 18'h2AAAA; pix_data = 1; @(negedge dotclk);
    pix_req = 0; cycles(2);
    chk("idle_wren", wren, 0);

    // Glitch line must not break or advance the run; a matching line resets it.
    send_line(800); send_line(800); send_line(300); send_line(800);
    cycles(4);
    chk("glitch_noclear", clearing, 0);
    send_line(640);
    send_line(800); send_line(800); send_line(640);
    send_line(800); send_line(800); send_line(800);
    cycles(4);
    chk("hyst_noclear", clearing, 0);
    send_line(800);
    chk("hyst_arm", clearing, 1);

    // Capture requests held through ARM and CLEAR are dropped.
    pix_req = 1; pix_addr = 18'h00155; pix_data = 1;
    cycles(5);
    chk("arm_idle", wren, 0);
    pulse_fs();
    wait_done("mode_clear");
    chk("mode_80", screen_mode, 0);
    cycles(3);
    chk("resume_waddr", waddr, 18'h00155);
    pix_req = 0;
    cycles(2);

    // force_clear mid-pass queues a second full pass for the next frame.
    force_clear = 1; @(negedge dotclk); force_clear = 0;
    cycles(3);
    pulse_fs();
    wait_addr(100, "fc_at100");
    force_clear = 1; @(negedge dotclk); force_clear = 0;
    wait_done("fc_pass1");
    cycles(10);
    chk("fc_wait_arm", clearing, 1);
    chk("fc_wait_wren", wren, 0);
    pulse_fs();
    wait_done("fc_pass2");
    chk("fc_mode_kept", screen_mode, 0);
    chk("fc_passes", pass_len.size(), 3);

    // frame_start coinciding with PASS->ARM is ignored; then reset mid-clear.
    force_clear = 1; @(negedge dotclk);
    force_clear = 0; frame_start = 1; @(negedge dotclk);
    frame_start = 0;
    cycles(5);
    chk("coinc_still_arm", clearing, 1);
    chk("coinc_no_write", wren, 0);
    pulse_fs();
    wait_addr(150, "rst_at150");
    rst_n = 0;
    #1;
    chk("abort_wren", wren, 0);
    chk("abort_waddr", waddr, 0);
    chk("abort_clearing", clearing, 0);
    chk("abort_mode", screen_mode, 1);
    cycles(2);
    rst_n = 1;
    d0 = n_done;
    pix_req = 1; pix_addr = 18'h00777; pix_data = 1;
    cycles(3);
    chk("post_rst_waddr", waddr, 18'h00777);
    pix_req = 0;
    cycles(20);
    chk("post_rst_nodone", n_done, d0);
    chk("post_rst_noclear", clearing, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
